fram_port_arb: RTL and testbench

FRAM_PORT_ARB -- requirements
Module: fram_port_arb

---
 rtl/fram_pkg.sv | 12 +
 rtl/fram_fill_eng.sv | 78 +++++++
 rtl/fram_port_arb.sv | 141 ++++++++++++++
 tb/tb_fram_port_arb.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fram_pkg.sv
// Shared fill-engine state encodings and default frame geometry for the frame RAM arbiter.
package fram_pkg;

    localparam int ADDR_END_DEF = 39999;
    localparam int AW_DEF       = 16;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } fill_st_t;

endpackage

// File: rtl/fram_fill_eng.sv
// Fill engine: walks the fill address from 0 to ADDR_END, one step per unstalled RUN cycle.
// Latency: RUN (and we_req) 1 cycle after start; done 1 cycle after the write at ADDR_END.
// Backpressure: stall freezes the address in RUN; abort returns to F_IDLE with no done.
module fram_fill_eng
    import fram_pkg::*;
#(
    parameter int ADDR_END = ADDR_END_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          stall,
    output logic [AW-1:0] addr,
    output logic          we_req,
    output logic          done
);

    localparam logic [AW-1:0] LP_END = AW'(ADDR_END);

    fill_st_t      r_state;
    fill_st_t      w_state_nxt;
    logic [AW-1:0] r_addr;
    logic          r_done;
    logic          w_adv;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_adv       = 1'b0;
        case (r_state)
            F_IDLE: begin
                if (start) begin
                    w_state_nxt = F_RUN;
                end
            end
            F_RUN: begin
                if (abort) begin
                    w_state_nxt = F_IDLE;
                end else if (!stall) begin
                    w_adv = 1'b1;
                    if (r_addr == LP_END) begin
                        w_state_nxt = F_IDLE;
                    end
                end
            end
            default: w_state_nxt = F_IDLE;
        endcase
    end

    // The address parks at ADDR_END after the last write; only a new start rewinds it.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_done <= 1'b0;
        end else begin
            if (r_state == F_IDLE && start) begin
                r_addr <= '0;
            end else if (w_adv && r_addr != LP_END) begin
                r_addr <= r_addr + AW'(1);
            end
            r_done <= w_adv && (r_addr == LP_END);
        end
    end

    assign addr   = r_addr;
    assign we_req = (r_state == F_RUN);
    assign done   = r_done;

endmodule

// File: rtl/fram_port_arb.sv
// Frame RAM write-port arbiter: UART pixel stream (fixed priority) over the fill engine.
// Latency: granted write on ram_* 1 cycle after request; done/abort pulses registered.
// Backpressure: none upstream (excess pixels dropped); fill stalls behind UART. Option: FRAM_OVR_CNT_EN.
module fram_port_arb
    import fram_pkg::*;
#(
    parameter int ADDR_END = ADDR_END_DEF,
    parameter int AW       = AW_DEF
) (
    input  logic          sclk,
    input  logic          rst_n,
    input  logic          frm_start,
    input  logic          pix_vld,
    input  logic [7:0]    pix_data,
    input  logic          fill_start,
    input  logic [7:0]    fill_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          fill_busy,
    output logic          frm_done,
    output logic          fill_done,
    output logic          fill_abort
`ifdef FRAM_OVR_CNT_EN
    ,
    output logic [15:0]   ovr_cnt
`endif
);

    localparam logic [AW-1:0] LP_END = AW'(ADDR_END);

    logic          r_frm_act;
    logic [AW-1:0] r_uart_addr;
    logic          r_frm_last;
    logic [7:0]    r_fill_col;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [7:0]    r_ram_din;
    logic          r_frm_done;
    logic          r_fill_done;
    logic          r_fill_abort;

    logic [AW-1:0] w_uart_base;
    logic          w_uart_gnt;
    logic          w_uart_last;
    logic          w_fill_st;
    logic          w_fill_req;
    logic          w_fill_gnt;
    logic [AW-1:0] w_fill_addr;
    logic          w_eng_done;

    // A frame start takes effect in its own cycle, so a coincident pixel lands at address 0.
    assign w_uart_base = frm_start ? '0 : r_uart_addr;
    assign w_uart_gnt  = pix_vld & (frm_start | r_frm_act);
    assign w_uart_last = w_uart_gnt & (w_uart_base == LP_END);
    assign w_fill_st   = fill_start & ~frm_start;
    assign w_fill_gnt  = w_fill_req & ~w_uart_gnt & ~frm_start;

    fram_fill_eng #(
        .ADDR_END (ADDR_END),
        .AW       (AW)
    ) u_fill_eng (
        .sclk   (sclk),
        .rst_n  (rst_n),
        .start  (w_fill_st),
        .abort  (frm_start),
        .stall  (w_uart_gnt),
        .addr   (w_fill_addr),
        .we_req (w_fill_req),
        .done   (w_eng_done)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_frm_act   <= 1'b0;
            r_uart_addr <= '0;
            r_frm_last  <= 1'b0;
            r_fill_col  <= '0;
        end else begin
            if (w_uart_gnt) begin
                r_frm_act   <= ~w_uart_last;
                r_uart_addr <= w_uart_last ? w_uart_base : w_uart_base + AW'(1);
            end else if (frm_start) begin
                r_frm_act   <= 1'b1;
                r_uart_addr <= '0;
            end
            r_frm_last <= w_uart_last;
            if (w_fill_st && !w_fill_req) begin
                r_fill_col <= fill_data;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_frm_done   <= 1'b0;
            r_fill_done  <= 1'b0;
            r_fill_abort <= 1'b0;
        end else begin
            r_ram_we <= w_uart_gnt | w_fill_gnt;
            if (w_uart_gnt) begin
                r_ram_addr <= w_uart_base;
                r_ram_din  <= pix_data;
            end else if (w_fill_gnt) begin
                r_ram_addr <= w_fill_addr;
                r_ram_din  <= r_fill_col;
            end
            r_frm_done   <= r_frm_last;
            r_fill_done  <= w_eng_done;
            r_fill_abort <= frm_start & w_fill_req;
        end
    end

`ifdef FRAM_OVR_CNT_EN
    logic [15:0] r_ovr_cnt;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= '0;
        end else if (frm_start) begin
            r_ovr_cnt <= '0;
        end else if (pix_vld && !r_frm_act && r_ovr_cnt != 16'hFFFF) begin
            r_ovr_cnt <= r_ovr_cnt + 16'd1;
        end
    end

    assign ovr_cnt = r_ovr_cnt;
`endif

    assign ram_we     = r_ram_we;
    assign ram_addr   = r_ram_addr;
    assign ram_din    = r_ram_din;
    assign fill_busy  = w_fill_req;
    assign frm_done   = r_frm_done;
    assign fill_done  = r_fill_done;
    assign fill_abort = r_fill_abort;

endmodule

// File: tb/tb_fram_port_arb.sv
// Bench for fram_port_arb: vector table for cycle-level arbitration, then long frame/fill/abort/reset runs.
module tb_fram_port_arb;

    localparam int END = 3999;

    logic        sclk;
    logic        rst_n;
    logic        frm_start;
    logic        pix_vld;
    logic [7:0]  pix_data;
    logic        fill_start;
    logic [7:0]  fill_data;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        fill_busy;
    logic        frm_done;
    logic        fill_done;
    logic        fill_abort;
`ifdef FRAM_OVR_CNT_EN
    logic [15:0] ovr_cnt;
`endif

    fram_port_arb #(
        .ADDR_END (END),
        .AW       (16)
    ) dut (
        .sclk       (sclk),
        .rst_n      (rst_n),
        .frm_start  (frm_start),
        .pix_vld    (pix_vld),
        .pix_data   (pix_data),
        .fill_start (fill_start),
        .fill_data  (fill_data),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .fill_busy  (fill_busy),
        .frm_done   (frm_done),
        .fill_done  (fill_done),
        .fill_abort (fill_abort)
`ifdef FRAM_OVR_CNT_EN
        ,
        .ovr_cnt    (ovr_cnt)
`endif
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic        fs;
        logic        pv;
        logic [7:0]  pd;
        logic        ls;
        logic [7:0]  ld;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  din;
        logic        busy;
        logic        fdn;
        logic        ldn;
        logic        ab;
    } vec_t;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic fs, input logic pv, input logic [7:0] pd,
                                input logic ls, input logic [7:0] ld, input logic we,
                                input logic [15:0] addr, input logic [7:0] din, input logic busy,
                                input logic fdn, input logic ldn, input logic ab);
        vec_t v;
        v.fs = fs; v.pv = pv; v.pd = pd; v.ls = ls; v.ld = ld;
        v.we = we; v.addr = addr; v.din = din; v.busy = busy;
        v.fdn = fdn; v.ldn = ldn; v.ab = ab;
        return v;
    endfunction

    task automatic idle_inputs();
        frm_start  = 1'b0;
        pix_vld    = 1'b0;
        pix_data   = 8'h00;
        fill_start = 1'b0;
        fill_data  = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge sclk);
        #1 rst_n = 1'b1;
    endtask

    vec_t vt[14];
    int   bad, bad2, n_wr, n_busy, n_done, done_at, first_wr, last_wr, n_ab, ab_at, np, drop_we, found;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        chk("reset ram_we", 32'(ram_we), 0);
        chk("reset ram_addr", 32'(ram_addr), 0);
        chk("reset ram_din", 32'(ram_din), 0);
        chk("reset fill_busy", 32'(fill_busy), 0);
        chk("reset frm_done", 32'(frm_done), 0);
        chk("reset fill_done", 32'(fill_done), 0);
        chk("reset fill_abort", 32'(fill_abort), 0);
        @(posedge sclk);
        #1 rst_n = 1'b1;

        //          fs   pv   pd     ls   ld     we   addr din    busy fdn  ldn  ab
        vt[0]  = mk(1'b0,1'b1,8'h99, 1'b0,8'h00, 1'b0,16'd0,8'h00, 1'b0,1'b0,1'b0,1'b0);
        vt[1]  = mk(1'b1,1'b1,8'h11, 1'b0,8'h00, 1'b1,16'd0,8'h11, 1'b0,1'b0,1'b0,1'b0);
        vt[2]  = mk(1'b0,1'b1,8'h22, 1'b0,8'h00, 1'b1,16'd1,8'h22, 1'b0,1'b0,1'b0,1'b0);
        vt[3]  = mk(1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0,16'd1,8'h22, 1'b0,1'b0,1'b0,1'b0);
        vt[4]  = mk(1'b1,1'b0,8'h00, 1'b1,8'h5A, 1'b0,16'd1,8'h22, 1'b0,1'b0,1'b0,1'b0);
        vt[5]  = mk(1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0,16'd1,8'h22, 1'b0,1'b0,1'b0,1'b0);
        vt[6]  = mk(1'b0,1'b1,8'h33, 1'b0,8'h00, 1'b1,16'd0,8'h33, 1'b0,1'b0,1'b0,1'b0);
        vt[7]  = mk(1'b0,1'b0,8'h00, 1'b1,8'h5A, 1'b0,16'd0,8'h33, 1'b1,1'b0,1'b0,1'b0);
        vt[8]  = mk(1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1,16'd0,8'h5A, 1'b1,1'b0,1'b0,1'b0);
        vt[9]  = mk(1'b0,1'b1,8'h44, 1'b0,8'h00, 1'b1,16'd1,8'h44, 1'b1,1'b0,1'b0,1'b0);
        vt[10] = mk(1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b1,16'd1,8'h5A, 1'b1,1'b0,1'b0,1'b0);
        vt[11] = mk(1'b0,1'b0,8'h00, 1'b1,8'hFF, 1'b1,16'd2,8'h5A, 1'b1,1'b0,1'b0,1'b0);
        vt[12] = mk(1'b1,1'b1,8'h55, 1'b0,8'h00, 1'b1,16'd0,8'h55, 1'b0,1'b0,1'b0,1'b1);
        vt[13] = mk(1'b0,1'b0,8'h00, 1'b0,8'h00, 1'b0,16'd0,8'h55, 1'b0,1'b0,1'b0,1'b0);

        for (int i = 0; i < 14; i++) begin
            frm_start  = vt[i].fs;
            pix_vld    = vt[i].pv;
            pix_data   = vt[i].pd;
            fill_start = vt[i].ls;
            fill_data  = vt[i].ld;
            @(posedge sclk);
            #1;
            chk($sformatf("v%0d ram_we", i), 32'(ram_we), 32'(vt[i].we));
            chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(vt[i].addr));
            chk($sformatf("v%0d ram_din", i), 32'(ram_din), 32'(vt[i].din));
            chk($sformatf("v%0d fill_busy", i), 32'(fill_busy), 32'(vt[i].busy));
            chk($sformatf("v%0d frm_done", i), 32'(frm_done), 32'(vt[i].fdn));
            chk($sformatf("v%0d fill_done", i), 32'(fill_done), 32'(vt[i].ldn));
            chk($sformatf("v%0d fill_abort", i), 32'(fill_abort), 32'(vt[i].ab));
        end

        // Full-frame fill with no UART traffic.
        do_reset();
        fill_data  = 8'hA5;
        fill_start = 1'b1;
        @(posedge sclk);
        #1;
        idle_inputs();
        n_wr = 0; bad = 0; n_busy = 0; n_done = 0; done_at = -1; first_wr = -1; last_wr = -1;
        for (int c = 1; c <= END + 10; c++) begin
            if (fill_busy) n_busy++;
            if (ram_we) begin
                if (32'(ram_addr) != n_wr || ram_din != 8'hA5) bad++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                n_wr++;
            end
            if (fill_done) begin
                n_done++;
                done_at = c;
            end
            @(posedge sclk);
            #1;
        end
        chk("fill write count", n_wr, END + 1);
        chk("fill write addr/data errors", bad, 0);
        chk("fill first write cycle", first_wr, 2);
        chk("fill writes contiguous", last_wr - first_wr, END);
        chk("fill busy cycles", n_busy, END + 1);
        chk("fill_done count", n_done, 1);
        chk("fill_done after last write", done_at, last_wr + 1);

        // Frame load with two overrun pixels past ADDR_END.
        do_reset();
        bad = 0; n_wr = 0; n_done = 0; done_at = -1; drop_we = 0;
        for (int i = 0; i <= END + 8; i++) begin
            frm_start = (i == 0);
            pix_vld   = (i >= 1 && i <= END + 3);
            pix_data  = 8'(i - 1);
            @(posedge sclk);
            #1;
            if (ram_we) n_wr++;
            if ((i - 1) >= 0 && (i - 1) <= END) begin
                if (!ram_we || 32'(ram_addr) != i - 1 || ram_din != 8'(i - 1)) bad++;
            end else if (ram_we) begin
                bad++;
            end
            if ((i == END + 2 || i == END + 3) && ram_we) drop_we++;
            if (frm_done) begin
                n_done++;
                done_at = i;
            end
        end
        idle_inputs();
        chk("frame write errors", bad, 0);
        chk("frame write count", n_wr, END + 1);
        chk("overrun pixels written", drop_we, 0);
        chk("frm_done count", n_done, 1);
        chk("frm_done cycle", done_at, END + 2);
`ifdef FRAM_OVR_CNT_EN
        chk("ovr_cnt after overrun", 32'(ovr_cnt), 2);
`endif

        // Fill aborted by a frame start, then sparse UART pixels.
        do_reset();
        fill_data  = 8'h3C;
        fill_start = 1'b1;
        @(posedge sclk);
        #1;
        idle_inputs();
        chk("abort test busy", 32'(fill_busy), 1);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(posedge sclk);
            #1;
            if (!ram_we || 32'(ram_addr) != k || ram_din != 8'h3C) bad++;
        end
        chk("pre-abort fill writes", bad, 0);
        bad = 0; bad2 = 0; n_ab = 0; ab_at = -1; np = 0; n_wr = 0;
        for (int j = 0; j <= 60; j++) begin
            frm_start = (j == 0);
            pix_vld   = (j > 0 && j % 3 == 0);
            pix_data  = 8'h80 + 8'(np);
            @(posedge sclk);
            #1;
            if (ram_we) n_wr++;
            if (pix_vld) begin
                if (!ram_we || 32'(ram_addr) != np || ram_din != 8'h80 + 8'(np)) bad++;
                np++;
            end else if (ram_we) begin
                bad++;
            end
            if (fill_abort) begin
                n_ab++;
                ab_at = j;
            end
            if (fill_done || fill_busy) bad2++;
        end
        idle_inputs();
        chk("abort uart write errors", bad, 0);
        chk("abort uart write count", n_wr, 20);
        chk("fill_abort count", n_ab, 1);
        chk("fill_abort cycle", ab_at, 0);
        chk("fill idle after abort", bad2, 0);

        // Reset asserted mid-fill.
        do_reset();
        fill_data  = 8'hC3;
        fill_start = 1'b1;
        @(posedge sclk);
        #1;
        idle_inputs();
        found = 0;
        for (int c = 0; c < END + 10 && found == 0; c++) begin
            if (ram_we && ram_addr == 16'd2000) begin
                found = 1;
            end else begin
                @(posedge sclk);
                #1;
            end
        end
        chk("fill reached 2000", found, 1);
        rst_n = 1'b0;
        #1;
        chk("midfill reset ram_we", 32'(ram_we), 0);
        chk("midfill reset ram_addr", 32'(ram_addr), 0);
        chk("midfill reset ram_din", 32'(ram_din), 0);
        chk("midfill reset fill_busy", 32'(fill_busy), 0);
        chk("midfill reset frm_done", 32'(frm_done), 0);
        chk("midfill reset fill_done", 32'(fill_done), 0);
        chk("midfill reset fill_abort", 32'(fill_abort), 0);
        @(posedge sclk);
        #1 rst_n = 1'b1;
        n_wr = 0; n_done = 0; n_busy = 0;
        for (int c = 0; c < END + 10; c++) begin
            @(posedge sclk);
            #1;
            if (ram_we) n_wr++;
            if (fill_done || fill_abort) n_done++;
            if (fill_busy) n_busy++;
        end
        chk("post-reset writes", n_wr, 0);
        chk("post-reset done/abort pulses", n_done, 0);
        chk("post-reset busy", n_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
